// File: rtl/clock_timekeeper.sv
// Time-of-day core: prescales clk to a 1 Hz tick and keeps packed-BCD hh:mm:ss.
// Define CLK_TWELVE_HOUR_EN for a 12 h display with PM flag; otherwise 24 h and pm is 0.
module clock_timekeeper #(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       inc_hr,
    input  logic       inc_min,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       sec_tick,
    output logic       pm
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
`ifdef CLK_TWELVE_HOUR_EN
    localparam logic [7:0] HR_RESET = 8'h12;
`else
    localparam logic [7:0] HR_RESET = 8'h00;
`endif

    // 00..59 in packed BCD, wrapping to 00.
    function automatic logic [7:0] inc_sexa(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5)
                return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
`ifdef CLK_TWELVE_HOUR_EN
        if (v == 8'h12)
            return 8'h01;
`else
        if (v == 8'h23)
            return 8'h00;
`endif
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [DIV_W-1:0] r_div_cnt;
    logic [7:0]       r_hr;
    logic [7:0]       r_min;
    logic [7:0]       r_sec;
    logic             r_sec_tick;

    logic       w_tick;
    logic       w_set;
    logic       w_min_adv;
    logic       w_hr_adv;
    logic [7:0] w_sec_next;
    logic [7:0] w_min_next;
    logic [7:0] w_hr_next;

    // The whole carry chain is decided from current state so every digit
    // lands on the same edge as the seconds advance.
    assign w_tick     = run && (r_div_cnt == DIV_LAST);
    assign w_set      = !run && (inc_hr || inc_min);
    assign w_min_adv  = (w_tick && (r_sec == 8'h59)) || (!run && inc_min);
    assign w_hr_adv   = (w_tick && (r_sec == 8'h59) && (r_min == 8'h59)) || (!run && inc_hr);
    assign w_sec_next = inc_sexa(r_sec);
    assign w_min_next = inc_sexa(r_min);
    assign w_hr_next  = inc_hour(r_hr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_hr       <= HR_RESET;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_tick <= w_tick;
            if (w_tick) begin
                r_div_cnt <= '0;
                r_sec     <= w_sec_next;
            end else if (w_set) begin
                // Setting the time restarts the current second from zero.
                r_div_cnt <= '0;
                r_sec     <= 8'h00;
            end else if (run) begin
                r_div_cnt <= r_div_cnt + DIV_ONE;
            end
            if (w_min_adv)
                r_min <= w_min_next;
            if (w_hr_adv)
                r_hr <= w_hr_next;
        end
    end

`ifdef CLK_TWELVE_HOUR_EN
    logic r_pm;

    always_ff @(posedge clk) begin
        if (rst)
            r_pm <= 1'b0;
        else if (w_hr_adv && (r_hr == 8'h11))
            r_pm <= ~r_pm;
    end

    assign pm = r_pm;
`else
    assign pm = 1'b0;
`endif

    assign hr_bcd   = r_hr;
    assign min_bcd  = r_min;
    assign sec_bcd  = r_sec;
    assign sec_tick = r_sec_tick;
endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper: reference model counts hours/minutes/seconds as integers.
module tb_clock_timekeeper;
    localparam int TD = 4;
`ifdef CLK_TWELVE_HOUR_EN
    localparam logic [7:0] HR_ZERO = 8'h12;
    localparam logic [7:0] HR_TOP  = 8'h11;
    localparam logic       PM_TOP  = 1'b1;
`else
    localparam logic [7:0] HR_ZERO = 8'h00;
    localparam logic [7:0] HR_TOP  = 8'h23;
    localparam logic       PM_TOP  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       inc_hr = 1'b0;
    logic       inc_min = 1'b0;
    logic [7:0] hr_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       sec_tick;
    logic       pm;

    clock_timekeeper #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .run(run), .inc_hr(inc_hr), .inc_min(inc_min),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .sec_tick(sec_tick), .pm(pm)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_h = 0, m_m = 0, m_s = 0, m_div = 0;
    logic m_tick = 1'b0;

    logic [25:0] w_obs;
    assign w_obs = {hr_bcd, min_bcd, sec_bcd, sec_tick, pm};

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [25:0] exp_vec();
        int   hd;
        logic p;
`ifdef CLK_TWELVE_HOUR_EN
        hd = (m_h % 12 == 0) ? 12 : m_h % 12;
        p  = (m_h >= 12);
`else
        hd = m_h;
        p  = 1'b0;
`endif
        return {bcd(hd), bcd(m_m), bcd(m_s), m_tick, p};
    endfunction

    // One clock edge with the given inputs; the model advances alongside.
    task automatic apply(input logic r, input logic rn, input logic ih, input logic im);
        int t;
        rst = r; run = rn; inc_hr = ih; inc_min = im;
        @(posedge clk);
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_div = 0; m_tick = 1'b0;
        end else if (rn) begin
            m_tick = 1'b0;
            if (m_div == TD - 1) begin
                m_div  = 0;
                t      = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h    = t / 3600;
                m_m    = (t / 60) % 60;
                m_s    = t % 60;
                m_tick = 1'b1;
            end else begin
                m_div++;
            end
        end else begin
            m_tick = 1'b0;
            if (ih || im) begin
                m_h   = (m_h + int'(ih)) % 24;
                m_m   = (m_m + int'(im)) % 60;
                m_s   = 0;
                m_div = 0;
            end
        end
        #1;
    endtask

    task automatic drive_pulses(input logic ih, input logic im, input int n);
        repeat (n) begin
            apply(1'b0, 1'b0, ih, im);
            apply(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        repeat (3) apply(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        n_vec++;
        if (w_obs !== exp_vec()) begin
            n_err++; $display("FAIL reset model: got %h want %h", w_obs, exp_vec());
        end
        n_vec++;
        if (w_obs !== {HR_ZERO, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset value: got %h want %h", w_obs, {HR_ZERO, 16'h0, 2'b0});
        end
    endtask

    task automatic test_first_tick();
        for (int c = 1; c <= 40; c++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL first_tick cyc %0d: got %h want %h", c, w_obs, exp_vec());
            end
            if (c == 4) begin
                n_vec++;
                if ({sec_bcd, sec_tick} !== {8'h01, 1'b1}) begin
                    n_err++; $display("FAIL first_tick edge4: got sec=%h tick=%b want sec=01 tick=1", sec_bcd, sec_tick);
                end
            end
            if (c == 40) begin
                n_vec++;
                if (sec_bcd !== 8'h10) begin
                    n_err++; $display("FAIL first_tick edge40: got sec=%h want 10", sec_bcd);
                end
            end
        end
    endtask

    task automatic test_set_mode();
        drive_pulses(1'b0, 1'b1, 58);
        repeat (12) apply(1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (w_obs !== exp_vec()) begin
            n_err++; $display("FAIL set_pre: got %h want %h", w_obs, exp_vec());
        end
        drive_pulses(1'b0, 1'b1, 3);
        n_vec++;
        if ({hr_bcd, min_bcd, sec_bcd, sec_tick} !== {HR_ZERO, 8'h01, 8'h00, 1'b0}) begin
            n_err++; $display("FAIL set_min_wrap: got %h:%h:%h want %h:01:00", hr_bcd, min_bcd, sec_bcd, HR_ZERO);
        end
        drive_pulses(1'b1, 1'b0, 25);
        n_vec++;
        if ({hr_bcd, min_bcd, pm} !== {8'h01, 8'h01, 1'b0}) begin
            n_err++; $display("FAIL set_hr_25: got %h:%h pm=%b want 01:01 pm=0", hr_bcd, min_bcd, pm);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if ({hr_bcd, min_bcd, sec_bcd} !== {8'h02, 8'h02, 8'h00}) begin
            n_err++; $display("FAIL set_both: got %h:%h:%h want 02:02:00", hr_bcd, min_bcd, sec_bcd);
        end
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1);
            n_vec++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL set_level %0d: got %h want %h", c, w_obs, exp_vec());
            end
        end
    endtask

    task automatic test_carry();
        drive_pulses(1'b1, 1'b0, 22);
        drive_pulses(1'b0, 1'b1, 55);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) drive_pulses(1'b0, 1'b1, 8);
            for (int c = 1; c <= 240; c++) begin
                apply(1'b0, 1'b1, 1'b0, 1'b0);
                n_vec++;
                if (w_obs !== exp_vec()) begin
                    n_err++; $display("FAIL carry p%0d cyc %0d: got %h want %h", pass, c, w_obs, exp_vec());
                end
                if (c == 240) begin
                    n_vec++;
                    if ({hr_bcd, min_bcd, sec_bcd, sec_tick} !== {HR_ZERO, (pass == 0) ? 8'h01 : 8'h10, 8'h00, 1'b1}) begin
                        n_err++; $display("FAIL carry p%0d result: got %h:%h:%h tick=%b", pass, hr_bcd, min_bcd, sec_bcd, sec_tick);
                    end
                end
            end
        end
    endtask

    task automatic test_rollover();
        drive_pulses(1'b1, 1'b0, 23);
        drive_pulses(1'b0, 1'b1, 49);
        for (int c = 1; c <= 240; c++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL rollover cyc %0d: got %h want %h", c, w_obs, exp_vec());
            end
            if (c == 236) begin
                n_vec++;
                if ({hr_bcd, min_bcd, sec_bcd, pm} !== {HR_TOP, 8'h59, 8'h59, PM_TOP}) begin
                    n_err++; $display("FAIL rollover top: got %h:%h:%h pm=%b want %h:59:59", hr_bcd, min_bcd, sec_bcd, pm, HR_TOP);
                end
            end
            if (c == 240) begin
                n_vec++;
                if (w_obs !== {HR_ZERO, 8'h00, 8'h00, 1'b1, 1'b0}) begin
                    n_err++; $display("FAIL rollover wrap: got %h want %h", w_obs, {HR_ZERO, 16'h0, 2'b10});
                end
            end
        end
    endtask

    task automatic test_freeze();
        int guard = 0;
        while (m_div != 2 && guard < 8) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        n_vec++;
        if (m_div != 2) begin
            n_err++; $display("FAIL freeze_setup: got div=%0d want 2", m_div);
        end
        for (int c = 0; c < 10; c++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL freeze hold %0d: got %h want %h", c, w_obs, exp_vec());
            end
        end
        apply(1'b0, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if (w_obs !== exp_vec() || sec_tick !== 1'b0) begin
            n_err++; $display("FAIL resume1: got %h want %h", w_obs, exp_vec());
        end
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (w_obs !== exp_vec() || sec_tick !== 1'b1) begin
            n_err++; $display("FAIL resume2: got %h want %h", w_obs, exp_vec());
        end
    endtask

    task automatic test_reset_priority();
        int guard = 0;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        drive_pulses(1'b1, 1'b0, 23);
        drive_pulses(1'b0, 1'b1, 59);
        while (!(m_h == 23 && m_m == 59 && m_s == 59 && m_div == TD - 1) && guard < 300) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        n_vec++;
        if (w_obs !== exp_vec() || guard >= 300) begin
            n_err++; $display("FAIL rst_prio setup: got %h want %h guard=%0d", w_obs, exp_vec(), guard);
        end
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (w_obs !== {HR_ZERO, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL rst_prio: got %h want %h", w_obs, {HR_ZERO, 16'h0, 2'b0});
        end
    endtask

    task automatic test_random();
        logic cur_run = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 19) == 0) cur_run = ~cur_run;
            apply(1'($urandom_range(0, 99) == 0), cur_run,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            n_vec++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL random cyc %0d: got %h want %h", c, w_obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_set_mode();
        test_carry();
        test_rollover();
        test_freeze();
        test_reset_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/clock_timekeeper.md
# clock_timekeeper

Timekeeping core of the digital alarm clock: divides the system clock down to a 1 Hz tick and keeps the time of day as packed BCD hours, minutes and seconds. It sits directly upstream of the top-level display/output logic in `tt_um_digital_alarm_clock`, which consumes `hr_bcd`/`min_bcd`/`sec_bcd`. It sits directly downstream of the button conditioning, which supplies single-cycle `inc_hr`/`inc_min` pulses. The time-set controls are honoured only while the clock is stopped.

## Interface
- `TICK_DIV`, default 1000: number of `clk` cycles per second; legal range ≥ 2. Benches use 4.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high; one clock, one synchronous active-high reset.
- `run`  in  1  1 = time advances; 0 = stopped, set mode.
- `inc_hr`  in  1  single-cycle pulse; advances hours by one. Honoured only when `run`=0.
- `inc_min`  in  1  single-cycle pulse; advances minutes by one. Honoured only when `run`=0.
- `hr_bcd`  out  8  hours as packed BCD: [7:4] tens digit (0–2), [3:0] ones digit.
- `min_bcd`  out  8  minutes as packed BCD, 00–59.
- `sec_bcd`  out  8  seconds as packed BCD, 00–59.
- `sec_tick`  out  1  one-cycle pulse, asserted in the cycle in which a new seconds value first appears.
- `pm`  out  1  PM flag; tied to 0 unless `CLK_TWELVE_HOUR_EN` is defined.

## Operation
- **Prescaler:** `div_cnt` counts 0 to TICK_DIV−1 while `run`=1 and holds while `run`=0. At terminal count (TICK_DIV−1, with `run`=1):
  - `div_cnt` returns to 0;
  - seconds advance.
- **Seconds:** ones digit 9 wraps to 0 and carries into tens. 59 → 00 carries into minutes.
- **Minutes:** same digit rules as seconds. 59 → 00 carries into hours.
- **Hours (24 h):** 00 → 23, then 23 → 00. Full rollover is 23:59:59 → 00:00:00 in a single edge.
- **Cascade:** all digit carries resolve in the same edge as the seconds advance. No output is ever visible in an intermediate, non-BCD or out-of-range state.
- **Set mode (`run`=0):**
  - `inc_min` adds 1 to minutes; 59 wraps to 00 with no carry into hours.
  - `inc_hr` adds 1 to hours, following the hour sequence, and does not affect minutes.
  - Either pulse also clears seconds to 00 and `div_cnt` to 0.
  - Simultaneous `inc_hr` and `inc_min` apply both increments on the same edge.
  - A level held high increments on every cycle; pulse shaping is done upstream.
- **`run`=1:** `inc_hr` and `inc_min` are ignored.
- **Reset:**
  - 24 h build: `hr`=0x00, `min`=0x00, `sec`=0x00, `sec_tick`=0, `div_cnt`=0.
  - 12 h build: `hr`=0x12, `pm`=0.
  - Reset takes priority over every other input, including in the middle of a cascade.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- First seconds advance after reset with `run` held 1: the edge at which `div_cnt`=TICK_DIV−1, i.e. the TICK_DIV-th rising edge after `rst` is released.
- From then on, seconds advance every TICK_DIV cycles exactly.
- `sec_tick` rises on the same edge that loads the new `sec_bcd` and stays high for 1 cycle.
- `sec_tick` is not asserted for set-mode changes (`inc_*`).
- Deasserting `run` freezes `div_cnt`. Reasserting `run` resumes counting from the frozen value, so there is no partial-second loss.
- Time-set latency: `inc_*` sampled at edge N is visible on the outputs after edge N.

## Configuration
- Macro: `CLK_TWELVE_HOUR_EN`.
- **Defined — 12 h mode:**
  - Hour sequence is 12, 01, 02 … 11, 12.
  - `pm` toggles whenever hours go 11 → 12, whether by cascade or by `inc_hr`.
  - Full rollover example: 11:59:59 with `pm`=1 becomes 12:00:00 with `pm`=0.
  - Hours tens digit is 0–1.
- **Undefined — 24 h mode:**
  - Hour sequence is 00–23.
  - `pm` is driven constant 0.

## Test plan
- **Reset and first tick:** TICK_DIV=4, `run`=1 from reset → outputs 00:00:00 with `sec_tick`=0. After edge 4, `sec_bcd`=0x01 with a one-cycle `sec_tick`. After edge 40, `sec_bcd`=0x10.
- **BCD and carry:** preload to 00:00:59 via the bench path, then tick → 00:01:00. From 00:09:59, tick → 00:10:00, with no intermediate value observed.
- **Full rollover:** from 23:59:59, tick → 00:00:00 on one edge. In the 12 h build, 11:59:59 with `pm`=1 → 12:00:00 with `pm`=0.
- **Set mode:**
  - `run`=0, then 3 pulses of `inc_min` from 00:58:xx → 00:01:00, hours unchanged.
  - 25 pulses of `inc_hr` from 00 → 01.
  - Simultaneous `inc_hr` + `inc_min` → both increment.
- **Freeze and guard:** `run`=0 mid-second with `div_cnt`=2 → outputs and `div_cnt` hold for 10 cycles. `inc_*` pulsed while `run`=1 → ignored. Reasserting `run` gives the next tick 2 cycles later.
- **Reset priority:** assert `rst` on the same edge as the 23:59:59 rollover and an `inc_hr` pulse → outputs 00:00:00 (12 h build: 12:00:00 with `pm`=0) and `sec_tick`=0.
